// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and single-cycle clear.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, one-deep inflight tracking against a 1-cycle imem,
// credit-based issue, and a FIFO of {pc, inst} entries for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 13,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_valid_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    output logic                     imem_req_o,
    output logic [IMEM_AW-1:0]       imem_addr_o,
    input  logic [XLEN-1:0]          imem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_inst_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_pc4_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [XLEN-1:0]          pc_debug_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    entry_t          head;
    entry_t          push_data;

    // Credits count both buffered entries and the response still in flight,
    // so a push can never land on a full FIFO.
    assign pop         = out_valid_o & out_ready_i;
    assign credit_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue       = !rst_i && !redirect_valid_i && (credit_used < (CW+1)'(DEPTH));
    assign push        = inflight && !redirect_valid_i && !rst_i;
    assign push_data   = '{pc: inflight_pc, inst: imem_rdata_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= XLEN'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid_i) begin
            fetch_pc <= redirect_pc_i & ~XLEN'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
            end
        end
    end

    sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (redirect_valid_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc[IMEM_AW-1:0];
    assign out_valid_o = (count != '0);
    assign out_inst_o  = head.inst;
    assign out_pc_o    = head.pc;
    assign out_pc4_o   = head.pc + XLEN'(PC_STEP);
    assign count_o     = count;
    assign pc_debug_o  = fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// transaction-level model of the fetch stream and credit budget.
module tb_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          IMEM_AW  = 13;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              redirect_valid_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              imem_req_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [XLEN-1:0]   imem_rdata_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   out_inst_o;
    logic [XLEN-1:0]   out_pc_o;
    logic [XLEN-1:0]   out_pc4_o;
    logic [$clog2(DEPTH):0] count_o;
    logic [XLEN-1:0]   pc_debug_o;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(RESET_PC)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_inst_o       (out_inst_o),
        .out_pc_o         (out_pc_o),
        .out_pc4_o        (out_pc4_o),
        .count_o          (count_o),
        .pc_debug_o       (pc_debug_o)
    );

    always #5 clk = ~clk;

    // Instruction memory: random contents, data valid only the cycle after a request.
    logic [31:0] imem [0:2047];
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= imem[imem_addr_o[12:2]];
        else            imem_rdata_i <= $urandom();
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the PC stream decode should see, the next PC to be requested,
    // and how many fetched-but-not-consumed instructions exist.
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;
    int          occ;
    int          last_issued;
    bit          prev_rst;
    int          popped;

    task automatic model_step();
        logic [31:0] e;
        bit          pop;
        bit          exp_req;
        if (rst_i) begin
            check("req_in_rst", 32'(imem_req_o), 32'd0);
            if (prev_rst) begin
                check("valid_in_rst", 32'(out_valid_o), 32'd0);
                check("count_in_rst", 32'(count_o), 32'd0);
                check("pc_in_rst", pc_debug_o, RESET_PC);
            end
            exp_pc = RESET_PC; exp_issue = RESET_PC;
            occ = 0; last_issued = 0; prev_rst = 1;
        end else begin
            prev_rst = 0;
            check("count", 32'(count_o), 32'(occ - last_issued));
            check("valid", 32'(out_valid_o), 32'((occ - last_issued) != 0));
            check("pc_debug", pc_debug_o, exp_issue);
            pop = out_valid_o && out_ready_i;
            if (pop) begin
                e = exp_pc;
                check("out_pc", out_pc_o, e);
                check("out_inst", out_inst_o, imem[e[12:2]]);
                check("out_pc4", out_pc4_o, e + 32'd4);
                exp_pc = exp_pc + 32'd4;
                popped++;
            end
            exp_req = !redirect_valid_i && ((occ - int'(pop)) < DEPTH);
            check("req", 32'(imem_req_o), 32'(exp_req));
            if (exp_req) begin
                check("addr", 32'(imem_addr_o), 32'(exp_issue[IMEM_AW-1:0]));
                exp_issue = exp_issue + 32'd4;
            end
            occ = occ - int'(pop) + int'(exp_req);
            last_issued = int'(exp_req);
            if (redirect_valid_i) begin
                exp_pc = redirect_pc_i & ~32'd3;
                exp_issue = exp_pc;
                occ = 0; last_issued = 0;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
        rst_i = rst; out_ready_i = rdy; redirect_valid_i = redir; redirect_pc_i = tgt;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) imem[i] = $urandom();
        rst_i = 1; out_ready_i = 0; redirect_valid_i = 0; redirect_pc_i = '0;
        prev_rst = 0; popped = 0;
        exp_pc = RESET_PC; exp_issue = RESET_PC; occ = 0; last_issued = 0;
        @(posedge clk); #1;

        // Startup with decode always ready: one instruction per cycle from C2.
        do_reset();
        popped = 0;
        for (int c = 0; c < 12; c++) cycle(0, 1, 0, 0);
        check("throughput_pops", 32'(popped), 32'd10);

        // Decode stalled: credit stops fetch at DEPTH, then drains in order.
        do_reset();
        for (int c = 0; c < 8; c++) cycle(0, 0, 0, 0);
        check("stall_count", 32'(count_o), 32'(DEPTH));
        for (int c = 0; c < 8; c++) cycle(0, 1, 0, 0);

        // Redirect with three buffered entries and one in flight.
        do_reset();
        for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0);
        check("pre_redirect_count", 32'(count_o), 32'd3);
        cycle(0, 0, 1, 32'h100);
        for (int c = 0; c < 8; c++) cycle(0, 1, 0, 0);

        // Redirect in the same cycle decode accepts head PC 0x20; target misaligned.
        do_reset();
        for (int c = 0; c < 10; c++) cycle(0, 1, 0, 0);
        check("head_before_redirect", out_pc_o, 32'h20);
        cycle(0, 1, 1, 32'h103);
        for (int c = 0; c < 6; c++) cycle(0, 1, 0, 0);

        // Reset wins over a concurrent redirect.
        cycle(1, 1, 1, 32'h400);
        check("rst_over_redirect_pc", pc_debug_o, RESET_PC);
        check("rst_over_redirect_cnt", 32'(count_o), 32'd0);
        for (int c = 0; c < 4; c++) cycle(0, 1, 0, 0);

        // PC wraps past the top of the address space.
        cycle(0, 1, 1, 32'hFFFF_FFF4);
        for (int c = 0; c < 8; c++) cycle(0, 1, 0, 0);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV32I core: the successor to the single-register PC, +4 adder and PC-select mux. It holds the fetch PC, issues requests to a synchronous (1-cycle latency) instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes entries through a valid/ready handshake. A redirect from execute (branch/jump) flushes all younger work and restarts fetch at the new target.

## Interface
- XLEN, 32: PC/instruction width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- IMEM_AW, 13: instruction-memory byte-address width.
- RESET_PC, 32'h0: fetch PC after reset.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- redirect_valid_i  in  1  execute requests a fetch restart.
- redirect_pc_i  in  XLEN  restart target; bits [1:0] ignored (treated as 0).
- imem_req_o  out  1  read request this cycle.
- imem_addr_o  out  IMEM_AW  byte address = fetch_pc[IMEM_AW-1:0].
- imem_rdata_i  in  XLEN  instruction, valid exactly one cycle after the request.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  decode accepts the head.
- out_inst_o  out  XLEN  head instruction.
- out_pc_o  out  XLEN  head PC.
- out_pc4_o  out  XLEN  head PC + 4 (link value for JAL/JALR writeback).
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- pc_debug_o  out  XLEN  current fetch PC.

## Operation
- State: fetch_pc, inflight flag plus inflight_pc, FIFO storage, rd/wr pointers, count.
- pop = out_valid_o & out_ready_i.
- Issue: imem_req_o = !rst_i & !redirect_valid_i & (count + inflight − pop < DEPTH). On issue: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps modulo 2^XLEN).
- Response: the cycle after an issue, if inflight and no redirect this cycle, push {inflight_pc, imem_rdata_i} into FIFO; inflight clears unless a new issue occurs the same cycle.
- Simultaneous push and pop: both happen; count unchanged. Push into a full FIFO cannot occur (credit rule guarantees it).
- Redirect (redirect_valid_i=1): a pop in that same cycle completes normally (the accepted head is the redirecting instruction or older); then FIFO cleared (count ← 0, pointers ← 0), inflight response discarded, fetch_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}, no issue that cycle. Redirect on consecutive cycles: the last one wins.
- No state machine beyond the inflight flag; flow is credit-driven.
- out_valid_o = (count ≠ 0); out_* driven from FIFO head, meaningless when out_valid_o=0.

## Timing
- Reset (rst_i high at edge): fetch_pc ← RESET_PC, inflight ← 0, count ← 0, pointers ← 0. While rst_i is high: imem_req_o=0, out_valid_o=0, count_o=0, pc_debug_o=RESET_PC after the first edge.
- Reset mid-operation overrides everything, including a concurrent redirect or push.
- Startup: first cycle after reset release (C0) request RESET_PC; data pushed at end of C1; out_valid_o=1 in C2 (request-to-valid latency 2 cycles).
- Sustained throughput one instruction/cycle with out_ready_i held high.
- Redirect in cycle R: first request to target in R+1, out_valid_o=0 in R+1 and R+2, target instruction valid in R+3.
- out_ready_i low: fetch continues until count + inflight = DEPTH, then imem_req_o=0 until a pop.

## Structure
- fetch_pkg: fetch_entry_t packed struct {pc, inst}; INST_NOP = 32'h0000_0013 for bench use.
- Sub-module sync_fifo #(type T, DEPTH): storage, pointers, count, synchronous clear; fetch_unit holds PC, inflight and credit logic.

## Test plan
- Reset release, RESET_PC=0, out_ready_i=1, memory word i = i: out_valid_o rises in C2 with out_pc_o=0, then PCs 4, 8, 12… one per cycle; out_pc4_o = out_pc_o + 4.
- out_ready_i=0 from reset with DEPTH=4: exactly 4 requests issued, count_o=4, imem_req_o=0 thereafter; raise out_ready_i → entries 0,4,8,12 in order, fetch resumes at 16 with no bubble beyond credit.
- Redirect to 0x100 while count=3 and a request inflight: FIFO empties, inflight data never appears, next outputs are 0x100, 0x104 from R+3.
- Redirect coinciding with a pop of head PC 0x20: 0x20 accepted, nothing else from old stream; redirect_pc_i=0x103 → fetch restarts at 0x100.
- rst_i asserted mid-stream with a redirect the same cycle: next state is reset state (fetch_pc=RESET_PC, count_o=0), redirect ignored.
- fetch_pc=0xFFFF_FFFC with free-running fetch: next request address wraps to 0, out_pc_o sequence …FFFC, 0000_0000.
